// File: rtl/tone_scheduler.sv
// Two-source square-wave tone scheduler: music notes play from a queue-less
// handshake, key-press effects pre-empt music and the music resumes afterwards.
module tone_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat,
  input  logic        mus_valid,
  input  logic [15:0] mus_half,
  input  logic [3:0]  mus_beats,
  output logic        mus_ready,
  input  logic        sfx_valid,
  input  logic [15:0] sfx_half,
  input  logic [3:0]  sfx_beats,
  output logic        sfx_ready,
  output logic        tone,
  output logic        busy,
  output logic        src
);
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {IDLE, PLAY_MUS, PLAY_SFX} state_t;

  state_t            state, state_next;
  logic [HALF_W-1:0] half, half_next, cnt, cnt_next, susp_half, susp_half_next;
  logic [BEAT_W-1:0] left, left_next, susp_left, susp_left_next;
  logic              tone_next, susp_valid, susp_valid_next;
  logic              mus_acc, sfx_acc, note_end;

  assign mus_ready = (state == IDLE) && !susp_valid && !sfx_valid;
  assign sfx_ready = (state != PLAY_SFX);
  assign mus_acc   = mus_valid && mus_ready;
  assign sfx_acc   = sfx_valid && sfx_ready;
  assign note_end  = beat && (left == BEAT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      half       <= '0;
      cnt        <= '0;
      left       <= '0;
      tone       <= 1'b0;
      susp_valid <= 1'b0;
      susp_half  <= '0;
      susp_left  <= '0;
      busy       <= 1'b0;
      src        <= 1'b0;
    end else begin
      state      <= state_next;
      half       <= half_next;
      cnt        <= cnt_next;
      left       <= left_next;
      tone       <= tone_next;
      susp_valid <= susp_valid_next;
      susp_half  <= susp_half_next;
      susp_left  <= susp_left_next;
      busy       <= (state_next != IDLE);
      src        <= (state_next == PLAY_SFX);
    end
  end

  always_comb begin
    state_next      = state;
    half_next       = half;
    cnt_next        = cnt;
    left_next       = left;
    tone_next       = tone;
    susp_valid_next = susp_valid;
    susp_half_next  = susp_half;
    susp_left_next  = susp_left;

    if (sfx_acc) begin
      // A music note that is ending on this very beat has nothing left to resume.
      if (state == PLAY_MUS && !note_end) begin
        susp_valid_next = 1'b1;
        susp_half_next  = half;
        susp_left_next  = left - BEAT_W'(beat);
      end
      state_next = PLAY_SFX;
      half_next  = sfx_half;
      left_next  = (sfx_beats == '0) ? BEAT_W'(1) : sfx_beats;
      cnt_next   = '0;
      tone_next  = 1'b0;
    end else if (mus_acc) begin
      state_next = PLAY_MUS;
      half_next  = mus_half;
      left_next  = (mus_beats == '0) ? BEAT_W'(1) : mus_beats;
      cnt_next   = '0;
      tone_next  = 1'b0;
    end else if (state != IDLE) begin
      if (half == '0) begin
        cnt_next  = '0;
        tone_next = 1'b0;
      end else if (cnt == half - HALF_W'(1)) begin
        cnt_next  = '0;
        tone_next = ~tone;
      end else begin
        cnt_next  = cnt + HALF_W'(1);
      end

      // Note end: resume a suspended music note or fall back to idle.
      if (note_end) begin
        cnt_next  = '0;
        tone_next = 1'b0;
        if (state == PLAY_SFX && susp_valid) begin
          state_next      = PLAY_MUS;
          half_next       = susp_half;
          left_next       = susp_left;
          susp_valid_next = 1'b0;
        end else begin
          state_next = IDLE;
          half_next  = '0;
          left_next  = '0;
        end
      end else if (beat) begin
        left_next = left - BEAT_W'(1);
      end
    end
  end
endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 I_CLK  input  1  single system clock; all state updates on its rising edge.
REQ-002 I_RST_N  input  1  reset, asynchronous, active-low.
REQ-003 I_BEAT  input  1  one-cycle beat tick from the slow divider; counts note duration.
REQ-004 I_MUS_VALID  input  1  music track offers a note.
REQ-005 I_MUS_HALF  input  16  music note half-period in I_CLK cycles; 0 = rest.
REQ-006 I_MUS_BEATS  input  4  music note length in beats; 0 treated as 1.
REQ-007 O_MUS_READY  output  1  music note accepted on a cycle with VALID&READY.
REQ-008 I_SFX_VALID  input  1  key-press sound effect offers a note.
REQ-009 I_SFX_HALF  input  16  effect half-period in I_CLK cycles; 0 = rest.
REQ-010 I_SFX_BEATS  input  4  effect length in beats; 0 treated as 1.
REQ-011 O_SFX_READY  output  1  effect accepted on a cycle with VALID&READY.
REQ-012 O_TONE  output  1  square-wave tone to the speaker.
REQ-013 O_BUSY  output  1  high whenever a note (music or effect) is playing.
REQ-014 O_SRC  output  1  source of the playing note: 0 music, 1 effect.

Function
REQ-015 States SHALL be IDLE, PLAY_MUS, PLAY_SFX; one shared tone counter; a suspend slot holding one music note (half-period, remaining beats, valid flag).
REQ-016 O_MUS_READY SHALL be combinational: high only in IDLE with suspend slot empty and I_SFX_VALID low.
REQ-017 O_SFX_READY SHALL be combinational: high in IDLE or PLAY_MUS; low in PLAY_SFX.
REQ-018 IDLE, both valid same cycle: effect SHALL be accepted, music held off (ready low).
REQ-019 Accept in IDLE: load half-period and beat count (0->1), clear tone counter, O_TONE<=0, go to PLAY_MUS or PLAY_SFX.
REQ-020 Effect accepted in PLAY_MUS (pre-emption): current music half-period and remaining beats SHALL be saved to the suspend slot, effect loaded as in REQ-019, go to PLAY_SFX.
REQ-021 I_BEAT on the acceptance cycle SHALL NOT be counted for the new note; counting starts the next cycle.
REQ-022 While playing, each I_BEAT SHALL decrement remaining beats; when I_BEAT arrives with remaining==1 the note ends on that edge.
REQ-023 Note end in PLAY_SFX with suspend slot valid: restore the saved music note (remaining beats as saved, tone phase restarted, O_TONE<=0), clear slot, go to PLAY_MUS; otherwise go to IDLE.
REQ-024 Note end in PLAY_MUS: go to IDLE; next note SHALL be acceptable the following cycle (one-cycle gap, O_TONE=0 in IDLE).
REQ-025 Tone counter, half H>0: counts 0..H-1, on reaching H-1 wraps to 0 and toggles O_TONE; tone period 2*H cycles; first toggle H cycles after load.
REQ-026 Half H=0 (rest): O_TONE SHALL be held 0; beats still counted; O_BUSY high.
REQ-027 Half-period and beats SHALL be captured at acceptance; later input changes SHALL have no effect on the playing note.
REQ-028 O_BUSY = state!=IDLE; O_SRC = (state==PLAY_SFX); IDLE drives O_SRC=0.
REQ-029 Counter arithmetic: 16-bit tone counter, 4-bit beat counter, no overflow possible (H<=65535, beats<=15).

Reset
REQ-030 I_RST_N low SHALL immediately force IDLE, O_TONE=0, O_BUSY=0, O_SRC=0, both READY per REQ-016/017 in IDLE, counters 0, suspend slot invalid — including mid-note and mid-pre-emption.
REQ-031 After release, first acceptance SHALL be possible on the first rising edge with I_RST_N high.

Verification
REQ-032 Music H=3, beats=2, beat pulse every 40 cycles -> O_TONE toggles every 3 cycles, O_BUSY high until 2nd counted beat, then IDLE, O_MUS_READY high.
REQ-033 Both valid in IDLE (music H=5, effect H=2 beats=1) -> O_SFX_READY=1, O_MUS_READY=0, O_SRC=1, tone period 4 cycles.
REQ-034 Music H=4 beats=5, effect H=2 beats=1 after 2 beats -> effect plays 1 beat, music resumes with 3 beats, O_SRC 0->1->0, O_TONE restarts at 0.
REQ-035 Beats=0 and H=0 note -> lasts exactly 1 beat, O_TONE stays 0, O_BUSY high.
REQ-036 I_BEAT coincident with acceptance of beats=1 note -> not counted; note ends on the next I_BEAT.
REQ-037 Reset asserted during pre-empting effect -> all outputs reset asynchronously; after release, no music resumes, IDLE accepts music.
